// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the ALU multiply sequencer: ALU control codes,
// sequencer state encoding and fixed datapath sizes.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq_port_mux.sv
// Owner select for the shared ALU: the CPU drives it unless the multiply
// sequencer owns it, in which case the CPU sees a zeroed result and zero flag.
module alu_port_mux
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  seq_own_i,
  input  logic [WIDTH-1:0]      seq_src1_i,
  input  logic [WIDTH-1:0]      seq_src2_i,
  input  logic [ALU_CTRL_W-1:0] seq_ctrl_i,
  input  logic [WIDTH-1:0]      cpu_src1_i,
  input  logic [WIDTH-1:0]      cpu_src2_i,
  input  logic [ALU_CTRL_W-1:0] cpu_ctrl_i,
  output logic [WIDTH-1:0]      cpu_result_o,
  output logic                  cpu_zero_o,
  output logic [WIDTH-1:0]      alu_src1_o,
  output logic [WIDTH-1:0]      alu_src2_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  input  logic [WIDTH-1:0]      alu_result_i,
  input  logic                  alu_zero_i
);

  // Route operands and results according to the current ALU owner.
  always_comb begin
    if (seq_own_i) begin
      alu_src1_o   = seq_src1_i;
      alu_src2_o   = seq_src2_i;
      alu_ctrl_o   = seq_ctrl_i;
      cpu_result_o = '0;
      cpu_zero_o   = 1'b0;
    end else begin
      alu_src1_o   = cpu_src1_i;
      alu_src2_o   = cpu_src2_i;
      alu_ctrl_o   = cpu_ctrl_i;
      cpu_result_o = alu_result_i;
      cpu_zero_o   = alu_zero_i;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared external ALU for one ADD
// per iteration and hands it back to the CPU when idle or finishing.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 6,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  input  logic [WIDTH-1:0] cpu_src1_i,
  input  logic [WIDTH-1:0] cpu_src2_i,
  input  logic [3:0]       cpu_ctrl_i,
  output logic [WIDTH-1:0] cpu_result_o,
  output logic             cpu_zero_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_own;
  logic             last_iter;

  // Finish on the final bit position, or once no set multiplier bits remain.
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) ||
                     ((EARLY_TERM == 1'b1) && (b_q[WIDTH-1:1] == '0));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start_i only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((EARLY_TERM == 1'b1) && (mplier_i == '0)) state_d = DONE;
          else                                           state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_iter) state_d = DONE;
        else           state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on start, one add/shift step per RUN cycle.
  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d = '0;
          a_d   = mcand_i;
          b_d   = mplier_i;
          cnt_d = '0;
        end else begin
          acc_d = acc_q;
        end
      end
      RUN: begin
        if (b_q[0]) acc_d = alu_result_i;
        else        acc_d = acc_q;
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: acc_d = acc_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_o   = 1'b0;
    done_o   = 1'b0;
    seq_own  = 1'b0;
    result_o = acc_q;
    case (state_q)
      RUN: begin
        busy_o  = 1'b1;
        seq_own = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  alu_port_mux #(.WIDTH(WIDTH)) u_mux (
    .seq_own_i    (seq_own),
    .seq_src1_i   (acc_q),
    .seq_src2_i   (a_q),
    .seq_ctrl_i   (ALU_ADD),
    .cpu_src1_i   (cpu_src1_i),
    .cpu_src2_i   (cpu_src2_i),
    .cpu_ctrl_i   (cpu_ctrl_i),
    .cpu_result_o (cpu_result_o),
    .cpu_zero_o   (cpu_zero_o),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i)
  );

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Owns the shared 32-bit ALU and arbitrates it between the CPU datapath and an iterative multiply sequencer.
- While idle, CPU operands and control pass straight through to the ALU.
- On `start_i`, the block takes the ALU and computes the low 32 bits of mcand × mplier by shift-and-add, issuing ALU ADD (ctrl 4'b0010) once per cycle.
- It stalls the CPU until the result is ready; the ALU stays an external combinational instance.

Parameters:
- WIDTH, 32, operand and result width; fixed to match the ALU.
- CNT_W, 6, iteration counter width; must hold WIDTH-1.
- EARLY_TERM, 1, 1 = finish as soon as the remaining multiplier bits are zero; 0 = always run WIDTH iterations.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  multiply request, sampled only in IDLE
- mcand_i  in  32  multiplicand, captured with start
- mplier_i  in  32  multiplier, captured with start
- busy_o  out  1  high in RUN; CPU must stall
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  32  product low word, held until next accepted start
- cpu_src1_i  in  32  CPU operand 1
- cpu_src2_i  in  32  CPU operand 2
- cpu_ctrl_i  in  4  CPU ALU control
- cpu_result_o  out  32  ALU result returned to CPU
- cpu_zero_o  out  1  ALU zero returned to CPU
- alu_src1_o  out  32  to ALU src1_i
- alu_src2_o  out  32  to ALU src2_i
- alu_ctrl_o  out  4  to ALU ctrl_i
- alu_result_i  in  32  from ALU result_o
- alu_zero_i  in  1  from ALU zero_o

Behaviour:
- The ALU's own rst input is tied to rst_i at the top level.
- **States**
  - IDLE, RUN, DONE; encoding lives in the package.
  - Registers: acc[31:0], a_reg[31:0], b_reg[31:0], cnt[CNT_W-1:0].
- **Reset (rst_i=0, asynchronous)**
  - state=IDLE; acc, a_reg, b_reg, cnt all 0.
  - busy_o=0, done_o=0, result_o=0.
  - A reset during RUN aborts the operation with no done_o.
- **IDLE**
  - alu_* = cpu_* combinationally; cpu_result_o=alu_result_i; cpu_zero_o=alu_zero_i.
  - On an edge with start_i=1: acc←0, a_reg←mcand_i, b_reg←mplier_i, cnt←0.
  - Next state is RUN, or DONE if mplier_i==0 and EARLY_TERM=1.
- **RUN**
  - Drives alu_src1_o=acc, alu_src2_o=a_reg, alu_ctrl_o=4'b0010.
  - cpu_result_o=0, cpu_zero_o=0; CPU inputs are ignored.
  - Each edge: if b_reg[0], acc←alu_result_i (carry out discarded, mod 2^32). Then a_reg←a_reg<<1, b_reg←b_reg>>1, cnt←cnt+1.
  - Go to DONE when cnt==WIDTH-1, or when EARLY_TERM=1 and (b_reg>>1)==0.
- **DONE**
  - One cycle: done_o=1, ALU returns to pass-through exactly as in IDLE. Next edge goes to IDLE.
  - start_i in DONE is ignored.
- **Outputs**
  - busy_o = (state==RUN); result_o = acc.
  - result_o is stable from DONE until the next accepted start.
- **Latency**
  - N = index of highest set bit of mplier + 1, or WIDTH if EARLY_TERM=0.
  - start accepted at edge E0; RUN updates at E1..EN; done_o high in the cycle after EN.
  - mplier=0 with EARLY_TERM=1: done_o high in the cycle after E0.
- **Other rules**
  - start_i while busy is ignored; there is no queueing.
  - The signed/unsigned distinction is irrelevant, because the low 32 product bits are identical for both.
  - Iteration is never wider than WIDTH; cnt does not wrap.

Decomposition:
- Shared package holds:
  - ALU control constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Natural sub-module: alu_port_mux, the combinational owner-select between CPU and sequencer for the alu_* and cpu_result/zero paths.
- The FSM, counter and datapath registers stay in alu_mul_seq.

Test Plan:
- mcand=6, mplier=7, start one cycle → busy_o 3 cycles, then done_o=1 with result_o=42; result_o still 42 ten cycles later.
- mcand=0x12345678, mplier=0 → no RUN cycle, done_o in cycle after start, result_o=0.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF → 32 RUN cycles, result_o=0x00000001; with EARLY_TERM=0, mplier=1 also takes 32 cycles, result=mcand.
- mcand=0xFFFFFFFD (−3), mplier=5 → result_o=0xFFFFFFF1; second start pulse asserted mid-RUN is ignored (single done_o).
- Idle pass-through: cpu_ctrl=4'b0110, src1=src2=5 → alu_ctrl_o=0110, cpu_result_o=0, cpu_zero_o=1. During RUN, cpu_result_o=0, cpu_zero_o=0, alu_ctrl_o=0010.
- rst_i low for one cycle at RUN iteration 2 of 6×7 → busy_o, result_o, done_o immediately 0, state IDLE, no done_o. A new start then yields 42.
